bit_mix_decode_ctrl: RTL and testbench
======================================

// Module: bit_mix_decode_ctrl
// PURPOSE
//  Multi-round sequencer for the bit_level_mixing_decode datapath. Accepts one 64-bit ciphertext block
//  plus its 64-bit final key over a valid/ready handshake and iterates the combinational mixing-decode
//  stage ROUNDS times, one round per clock, with a per-round byte-rotated key. Presents the plaintext
//  on a valid/ready output. Sits between the input FIFO and the output packer of the decrypt path.
// PARAMETERS
//  ROUNDS  4  number of mixing-decode rounds per block (legal 1..16)
//  CNT_W   4  round counter width; must satisfy 2**CNT_W >= ROUNDS
// PORTS
//  clk        in   1     single clock, all logic rising-edge
//  rst        in   1     synchronous, active-high reset
//  abort      in   1     synchronous flush: drop in-flight block, return to IDLE
//  in_valid   in   1     in_data/in_key valid
//  in_ready   out  1     controller can accept a block (IDLE only)
//  in_data    in   64    [0:63] ciphertext block, bit 0 = MSB
//  in_key     in   64    [0:63] final key for this block
//  out_valid  out  1     out_data holds a finished block
//  out_ready  in   1     downstream accepts out_data
//  out_data   out  64    [0:63] decoded block
//  busy       out  1     high in RUN or DONE
//  round_cnt  out  CNT_W index of the round being executed (0 = first)
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=0 during the reset cycle, 1 the cycle after; out_valid=0,
//   out_data=0, busy=0, round_cnt=0; data/key registers cleared.
//  FSM IDLE -> RUN on in_valid&in_ready: data_reg<=in_data; key_reg<=rotl(in_key,8*(ROUNDS-1)) mod 64.
//  RUN: each cycle data_reg<=mix_decode(data_reg,key_reg); key_reg<=rotr(key_reg,8); round_cnt++.
//   Keys are applied in reverse of encode order: round r uses rotl(in_key, 8*(ROUNDS-1-r)).
//   After round ROUNDS-1 completes: -> DONE, round_cnt<=0.
//  DONE: out_valid=1, out_data=data_reg (held stable until accepted). out_valid&out_ready -> IDLE.
//  Latency: handshake at cycle T -> out_valid first high at T+ROUNDS+1 (registered output). ROUNDS=1
//   gives a single RUN cycle. Throughput 1 block per ROUNDS+2 cycles minimum (no overlap).
//  in_ready = (state==IDLE) & ~abort; combinational from state/abort only, never from in_valid.
//  out_data is 0 whenever out_valid=0 (no stale plaintext leaks onto the bus).
//  abort: any state -> IDLE next cycle, out_valid=0, data/key registers zeroed; abort with in_valid
//   in IDLE: no accept. abort in DONE with out_ready: transfer discarded (abort wins).
//  rst dominates abort; rst mid-RUN discards the block identically.
//  in_valid deasserted/changed while not ready: ignored; no buffering beyond one block.
//  Rotations are 64-bit wrap-around in [0:63] order: rotl by 8 moves byte 1 into byte 0.
// STRUCTURE
//  Shared package bit_mix_pkg: ROUND_ROT=8, BLK_W=64, state enum {IDLE,RUN,DONE} (2-bit encoding),
//   rotl64/rotr64 functions used by the encode-side controller as well.
//  One sub-module instance: bit_level_mixing_decode (data_in=data_reg, final_key=key_reg),
//   purely combinational; controller owns all registers. No other sub-modules.
// TESTING
//  Golden model: software chain of ROUNDS mix-decode calls with the key schedule above.
//  1 ROUNDS=1, in_data=64'h80c8a8764cae9bef, in_key=64'h0102030405060708 -> out_valid at T+2,
//    out_data == single mix_decode(in_data,in_key) from the golden model.
//  2 ROUNDS=4, same vectors -> round_cnt 0,1,2,3 on RUN cycles; keys seen at datapath
//    64'h0405060708010203, 64'h0304050607080102, 64'h0203040506070801, 64'h0102030405060708;
//    out_valid at T+5, out_data == golden.
//  3 Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid/out_data stable, in_ready=0,
//    in_valid pulses ignored; out_ready=1 -> IDLE next cycle, in_ready=1.
//  4 abort asserted in RUN at round 2 -> next cycle IDLE, out_valid=0, out_data=0, busy=0; next
//    block (in_data=64'h0, in_key=64'hffffffffffffffff) decodes matching golden, no residue.
//  5 rst asserted during DONE with out_ready=1 -> no transfer counted, all outputs at reset values.
//  6 Back-to-back: 8 random blocks, in_valid and out_ready always 1 -> each out matches golden,
//    spacing ROUNDS+2 cycles, in_ready never high outside IDLE.

Source files
------------

// File: rtl/bit_mix_pkg.sv
// Shared types, widths and rotation helpers for the bit-level mixing encode/decode controllers.
package bit_mix_pkg;

   localparam int unsigned BLK_W     = 64;
   localparam int unsigned ROUND_ROT = 8;

   typedef logic [0:BLK_W-1] blk_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Working block plus the key for the round about to execute.
   typedef struct packed {
      blk_t data;
      blk_t key;
   } blk_ctx_t;

   // Wrap-around rotations in [0:63] order: rotl by 8 moves byte 1 into byte 0.
   function automatic blk_t rotl64(input blk_t x, input int unsigned n);
      int unsigned s;
      s = n % BLK_W;
      return (x << s) | (x >> (BLK_W - s));
   endfunction

   function automatic blk_t rotr64(input blk_t x, input int unsigned n);
      return rotl64(x, BLK_W - (n % BLK_W));
   endfunction

endpackage

// File: rtl/bit_mix_decode_ctrl_if.sv
// Block input / plaintext output handshake bundle for the decode controller.
interface bit_mix_decode_ctrl_if;
   import bit_mix_pkg::*;

   logic in_valid;
   logic in_ready;
   blk_t in_data;
   blk_t in_key;
   logic out_valid;
   logic out_ready;
   blk_t out_data;

   modport master (
      output in_valid, in_data, in_key, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, in_key, out_ready,
      output in_ready, out_valid, out_data
   );

endinterface

// File: rtl/bit_level_mixing_decode.sv
// One combinational mixing-decode round: key whitening, bit permutation, then a nonlinear neighbour mix.
module bit_level_mixing_decode
   import bit_mix_pkg::*;
(
   input  blk_t data_in,
   input  blk_t final_key,
   output blk_t data_out
);

   blk_t whitened;
   blk_t permuted;

   // Bit i of the permuted word takes whitened bit (9*i+5) mod 64; 9 is odd so this is a bijection.
   always_comb begin
      whitened = data_in ^ final_key;
      permuted = '0;
      for (int i = 0; i < 64; i++) begin
         permuted[6'(i)] = whitened[6'((9 * i + 5) % 64)];
      end
      data_out = permuted ^ (rotr64(permuted, 1) & rotr64(permuted, 2));
   end

endmodule

// File: rtl/bit_mix_decode_ctrl.sv
// Multi-round sequencer: accepts one block, runs ROUNDS mixing-decode rounds with a rotating key, emits plaintext.
module bit_mix_decode_ctrl
   import bit_mix_pkg::*;
#(
   parameter int unsigned ROUNDS = 4,
   parameter int unsigned CNT_W  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 abort,
   bit_mix_decode_ctrl_if.slave bus,
   output logic                 busy,
   output logic [CNT_W-1:0]     round_cnt
);

   localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(ROUNDS - 1);
   localparam int unsigned      KEY_PRE  = (ROUND_ROT * (ROUNDS - 1)) % BLK_W;

   if (ROUNDS < 1 || ROUNDS > 16 || (2 ** CNT_W) < ROUNDS) begin : g_bad_params
      $error("bit_mix_decode_ctrl: illegal ROUNDS/CNT_W combination");
   end

   state_e           state_q;
   blk_ctx_t         ctx_q;
   logic [CNT_W-1:0] cnt_q;
   logic             out_valid_q;
   blk_t             out_data_q;
   logic             busy_q;
   blk_t             mix_out;
   logic             in_ready_c;

   bit_level_mixing_decode u_mix (
      .data_in   (ctx_q.data),
      .final_key (ctx_q.key),
      .data_out  (mix_out)
   );

   // Ready only in IDLE and never while a flush or reset is being applied.
   assign in_ready_c   = (state_q == IDLE) && !abort && !rst;
   assign bus.in_ready = in_ready_c;

   always_ff @(posedge clk) begin
      if (rst || abort) begin
         state_q     <= IDLE;
         ctx_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid && in_ready_c) begin
                  state_q    <= RUN;
                  ctx_q.data <= bus.in_data;
                  ctx_q.key  <= rotl64(bus.in_key, KEY_PRE);
                  cnt_q      <= '0;
                  busy_q     <= 1'b1;
               end
            end
            RUN: begin
               ctx_q.data <= mix_out;
               ctx_q.key  <= rotr64(ctx_q.key, ROUND_ROT);
               if (cnt_q == LAST_RND) begin
                  state_q     <= DONE;
                  cnt_q       <= '0;
                  out_valid_q <= 1'b1;
                  out_data_q  <= mix_out;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state_q     <= IDLE;
                  ctx_q       <= '0;
                  out_valid_q <= 1'b0;
                  out_data_q  <= '0;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state_q     <= IDLE;
               ctx_q       <= '0;
               cnt_q       <= '0;
               out_valid_q <= 1'b0;
               out_data_q  <= '0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign busy          = busy_q;
   assign round_cnt     = cnt_q;

endmodule

// File: tb/tb_bit_mix_decode_ctrl.sv
// Directed and random checks of bit_mix_decode_ctrl (ROUNDS=4 and ROUNDS=1) against a software golden chain.
module tb_bit_mix_decode_ctrl;

   localparam int unsigned R4 = 4;

   logic       clk;
   logic       rst;
   logic       abort4;
   logic       abort1;
   logic       busy4;
   logic       busy1;
   logic [3:0] rcnt4;
   logic [3:0] rcnt1;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int last_hs  = 0;

   bit_mix_decode_ctrl_if bus4 ();
   bit_mix_decode_ctrl_if bus1 ();

   bit_mix_decode_ctrl #(.ROUNDS(R4), .CNT_W(4)) dut4 (
      .clk       (clk),
      .rst       (rst),
      .abort     (abort4),
      .bus       (bus4.slave),
      .busy      (busy4),
      .round_cnt (rcnt4)
   );

   bit_mix_decode_ctrl #(.ROUNDS(1), .CNT_W(4)) dut1 (
      .clk       (clk),
      .rst       (rst),
      .abort     (abort1),
      .bus       (bus1.slave),
      .busy      (busy1),
      .round_cnt (rcnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Reference model: bits indexed in [0:63] order, i.e. bit i is numeric bit 63-i.
   function automatic logic [63:0] mix_m(input logic [63:0] d, input logic [63:0] k);
      bit          t[64];
      bit          p[64];
      logic [63:0] v;
      logic [63:0] r;
      v = d ^ k;
      r = '0;
      for (int i = 0; i < 64; i++) t[i] = v[63 - i];
      for (int i = 0; i < 64; i++) p[i] = t[(9 * i + 5) % 64];
      for (int i = 0; i < 64; i++) r[63 - i] = p[i] ^ (p[(i + 63) % 64] & p[(i + 62) % 64]);
      return r;
   endfunction

   function automatic logic [63:0] rotl_m(input logic [63:0] k, input int s);
      logic [127:0] w;
      w = {k, k} << (s % 64);
      return w[127:64];
   endfunction

   function automatic logic [63:0] golden(input logic [63:0] d, input logic [63:0] k, input int rounds);
      logic [63:0] x;
      x = d;
      for (int r = 0; r < rounds; r++) x = mix_m(x, rotl_m(k, 8 * (rounds - 1 - r)));
      return x;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Drives one block into dut4 and follows it to DONE; leaves out_ready untouched and stays in DONE.
   task automatic run_block(input logic [63:0] d, input logic [63:0] k, input bit chk_keys,
                            input bit hold_valid, input bit chk_spacing);
      int          w;
      logic [63:0] exp;
      w = 0;
      while (!bus4.in_ready && w < 20) begin
         tick();
         w++;
      end
      check("in_ready_wait", 64'(bus4.in_ready), 64'd1);
      if (chk_spacing) check("spacing", 64'(cyc - last_hs), 64'(R4 + 2));
      last_hs       = cyc;
      exp           = golden(d, k, R4);
      bus4.in_data  = d;
      bus4.in_key   = k;
      bus4.in_valid = 1'b1;
      for (int r = 0; r < int'(R4); r++) begin
         tick();
         if (!hold_valid) bus4.in_valid = 1'b0;
         check("run_round_cnt", 64'(rcnt4), 64'(r));
         check("run_busy", 64'(busy4), 64'd1);
         check("run_out_valid", 64'(bus4.out_valid), 64'd0);
         check("run_out_data", bus4.out_data, 64'd0);
         check("run_in_ready", 64'(bus4.in_ready), 64'd0);
         if (chk_keys) check("run_key", dut4.ctx_q.key, rotl_m(k, 8 * (int'(R4) - 1 - r)));
      end
      tick();
      check("done_out_valid", 64'(bus4.out_valid), 64'd1);
      check("done_out_data", bus4.out_data, exp);
      check("done_busy", 64'(busy4), 64'd1);
      check("done_round_cnt", 64'(rcnt4), 64'd0);
      check("done_in_ready", 64'(bus4.in_ready), 64'd0);
   endtask

   initial begin
      logic [63:0] d;
      logic [63:0] k;
      logic [63:0] exp;

      rst            = 1'b1;
      abort4         = 1'b0;
      abort1         = 1'b0;
      bus4.in_valid  = 1'b0;
      bus4.in_data   = '0;
      bus4.in_key    = '0;
      bus4.out_ready = 1'b0;
      bus1.in_valid  = 1'b0;
      bus1.in_data   = '0;
      bus1.in_key    = '0;
      bus1.out_ready = 1'b0;

      // Reset values, in_ready low while rst is held, high afterwards.
      repeat (2) tick();
      check("rst_in_ready", 64'(bus4.in_ready), 64'd0);
      check("rst_out_valid", 64'(bus4.out_valid), 64'd0);
      check("rst_out_data", bus4.out_data, 64'd0);
      check("rst_busy", 64'(busy4), 64'd0);
      check("rst_round_cnt", 64'(rcnt4), 64'd0);
      check("rst_in_ready_r1", 64'(bus1.in_ready), 64'd0);
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", 64'(bus4.in_ready), 64'd1);
      check("post_rst_in_ready_r1", 64'(bus1.in_ready), 64'd1);

      // ROUNDS=1: single round, out_valid two cycles after the handshake cycle.
      d = 64'h80c8a8764cae9bef;
      k = 64'h0102030405060708;
      tick();
      bus1.in_data  = d;
      bus1.in_key   = k;
      bus1.in_valid = 1'b1;
      tick();
      bus1.in_valid = 1'b0;
      check("r1_run_out_valid", 64'(bus1.out_valid), 64'd0);
      check("r1_run_busy", 64'(busy1), 64'd1);
      check("r1_run_round_cnt", 64'(rcnt1), 64'd0);
      tick();
      check("r1_out_valid", 64'(bus1.out_valid), 64'd1);
      check("r1_out_data", bus1.out_data, mix_m(d, k));
      bus1.out_ready = 1'b1;
      tick();
      check("r1_idle_in_ready", 64'(bus1.in_ready), 64'd1);
      check("r1_idle_out_data", bus1.out_data, 64'd0);

      // ROUNDS=4 with key schedule visibility.
      run_block(d, k, 1'b1, 1'b0, 1'b0);
      check("r4_key_sched_r0", rotl_m(k, 24), 64'h0405060708010203);
      bus4.out_ready = 1'b1;
      tick();
      check("r4_idle_in_ready", 64'(bus4.in_ready), 64'd1);
      check("r4_idle_out_valid", 64'(bus4.out_valid), 64'd0);

      // Backpressure in DONE: output held, in_valid pulses ignored.
      bus4.out_ready = 1'b0;
      d   = {$urandom, $urandom};
      k   = {$urandom, $urandom};
      exp = golden(d, k, R4);
      run_block(d, k, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         bus4.in_valid = 1'(i % 2);
         bus4.in_data  = {$urandom, $urandom};
         tick();
         check("bp_out_valid", 64'(bus4.out_valid), 64'd1);
         check("bp_out_data", bus4.out_data, exp);
         check("bp_in_ready", 64'(bus4.in_ready), 64'd0);
      end
      bus4.in_valid  = 1'b0;
      bus4.out_ready = 1'b1;
      tick();
      check("bp_release_in_ready", 64'(bus4.in_ready), 64'd1);
      check("bp_release_busy", 64'(busy4), 64'd0);

      // Abort at round 2, then abort with in_valid in IDLE, then a clean block.
      bus4.in_data  = {$urandom, $urandom};
      bus4.in_key   = {$urandom, $urandom};
      bus4.in_valid = 1'b1;
      tick();
      bus4.in_valid = 1'b0;
      tick();
      tick();
      check("abort_at_round", 64'(rcnt4), 64'd2);
      abort4 = 1'b1;
      #1;
      check("abort_in_ready", 64'(bus4.in_ready), 64'd0);
      tick();
      abort4 = 1'b0;
      #1;
      check("abort_out_valid", 64'(bus4.out_valid), 64'd0);
      check("abort_out_data", bus4.out_data, 64'd0);
      check("abort_busy", 64'(busy4), 64'd0);
      check("abort_round_cnt", 64'(rcnt4), 64'd0);
      check("abort_data_reg", dut4.ctx_q.data, 64'd0);
      check("abort_key_reg", dut4.ctx_q.key, 64'd0);
      check("abort_idle_in_ready", 64'(bus4.in_ready), 64'd1);
      tick();
      abort4        = 1'b1;
      bus4.in_valid = 1'b1;
      tick();
      abort4        = 1'b0;
      bus4.in_valid = 1'b0;
      check("abort_no_accept_busy", 64'(busy4), 64'd0);
      run_block(64'h0, 64'hffffffffffffffff, 1'b0, 1'b0, 1'b0);
      tick();
      check("post_abort_idle", 64'(busy4), 64'd0);

      // Reset in DONE with out_ready high discards the block.
      bus4.out_ready = 1'b0;
      run_block({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0);
      bus4.out_ready = 1'b1;
      rst            = 1'b1;
      tick();
      check("rst_done_out_valid", 64'(bus4.out_valid), 64'd0);
      check("rst_done_out_data", bus4.out_data, 64'd0);
      check("rst_done_busy", 64'(busy4), 64'd0);
      check("rst_done_round_cnt", 64'(rcnt4), 64'd0);
      check("rst_done_in_ready", 64'(bus4.in_ready), 64'd0);
      rst = 1'b0;
      tick();
      check("rst_done_release", 64'(bus4.in_ready), 64'd1);

      // Back-to-back random blocks with in_valid and out_ready held high.
      bus4.out_ready = 1'b1;
      for (int b = 0; b < 8; b++) begin
         run_block({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b1, b != 0);
         tick();
      end
      bus4.in_valid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
